// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out MSB-first on x, one bit per clock.
// Optional even-parity bit after the LSB when SERIAL_PARITY_EN is defined.
module serial_bit_source #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             x_d, x_valid_d, x_last_d;
  logic             accept;
  logic             last_bit;

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef SERIAL_PARITY_EN
  logic par_q, par_d;
  assign din_ready = (state_q == StIdle) || (state_q == StPar);
`else
  assign din_ready = (state_q == StIdle) || last_bit;
`endif

  assign accept = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: ;
      StShift: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (last_bit) begin
          cnt_d = '0;
`ifdef SERIAL_PARITY_EN
          state_d = StPar;
`else
          state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPar:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept is only possible in a frame-final cycle, so it overrides the step above.
    if (accept) begin
      shreg_d = din;
      cnt_d   = '0;
      state_d = StShift;
`ifdef SERIAL_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

  // Outputs are registered versions of what the next state will present.
  always_comb begin
    x_d       = 1'b0;
    x_valid_d = (state_d != StIdle);
    x_last_d  = 1'b0;
    if (state_d == StShift) begin
      x_d = shreg_d[WIDTH-1];
`ifndef SERIAL_PARITY_EN
      x_last_d = (cnt_d == LastCnt);
`endif
    end
`ifdef SERIAL_PARITY_EN
    if (state_d == StPar) begin
      x_d      = par_d;
      x_last_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      x_last  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      x_last  <= x_last_d;
`ifdef SERIAL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial front end for the single-bit sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock, on `x`. The detector consumes `x` directly. `x_valid` and `x_last` mark which cycles carry frame bits. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 8: data word width; legal range 2–32.
- `clk`  input  1: sole clock; all state changes on its rising edge.
- `rst`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `din`  input  WIDTH: word to serialize; sampled only on an accepted handshake.
- `din_valid`  input  1: `din` holds a word to transfer.
- `din_ready`  output  1: block can accept a word this cycle.
- `x`  output  1: serial bit to the detector (registered).
- `x_valid`  output  1: `x` carries a frame bit this cycle (registered).
- `x_last`  output  1: current bit is the final bit of the frame (registered).

## Operation
- States: IDLE and SHIFT. The parity variant adds PAR.
- Handshake: a word is accepted at a rising edge where `din_valid && din_ready` is true.
- `din_ready` is combinational from state:
  - 1 in IDLE.
  - 1 in the final-bit cycle of a frame. This is the last data bit without parity, or the PAR cycle with parity.
  - 0 otherwise.
- On accept:
  - `din` loads into the shift register and the bit counter clears to 0.
  - State becomes SHIFT.
  - The MSB drives `x` with `x_valid` = 1.
- SHIFT:
  - Each edge shifts the register left by one and increments the counter.
  - `x` = current MSB.
  - The counter value WIDTH-1 marks the last data bit.
- After the last data bit:
  - If a word is accepted on that same edge, the next frame's MSB follows in the next cycle with no gap.
  - Otherwise the state goes to IDLE (or to PAR when parity is enabled).
- IDLE outputs: `x` = 0, `x_valid` = 0, `x_last` = 0.
- `din_valid` while `din_ready` = 0 is ignored. The upstream holds the word until it is accepted, and no word is lost or duplicated.
- `din` changing while not accepted has no effect.
- Reset asserted in any state, including mid-frame:
  - On that edge the state goes to IDLE, the counter to 0 and the shift register to 0.
  - `x`, `x_valid` and `x_last` go to 0.
  - The partial frame is abandoned.
  - Reset overrides a simultaneous handshake.

## Timing
- Reset values: `x` = 0, `x_valid` = 0, `x_last` = 0, state IDLE, so `din_ready` = 1.
- Latency: a word accepted at edge k puts bit WIDTH-1 on `x` after edge k, bit WIDTH-2 after edge k+1, and so on. Each bit is held exactly one cycle.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- `x_last` is high for exactly one cycle per frame, coincident with the final bit.
- Sustained throughput is one word per WIDTH (or WIDTH+1) cycles when `din_valid` stays high.
- The counter is ceil(log2(WIDTH+1)) bits and never exceeds WIDTH.

## Configuration
- Macro: `SERIAL_PARITY_EN`.
- Defined:
  - An even-parity bit, the XOR of all WIDTH data bits captured at accept, is sent in a PAR state after the LSB.
  - `x_last` is high on the parity bit, not on the LSB.
  - `din_ready` = 1 during PAR.
- Undefined:
  - There is no PAR state and the frame is WIDTH bits.
  - `x_last` is high on the LSB.
  - No parity logic is present.

## Test plan
- Reset: hold `rst` = 0 for 3 edges with `din_valid` = 1 -> `x`/`x_valid`/`x_last` = 0 and `din_ready` = 1 throughout; no word accepted.
- Single word, WIDTH = 8, `din` = 8'hA5 accepted at edge 0 -> `x` = 1,0,1,0,0,1,0,1 in cycles 1–8; `x_valid` high in cycles 1–8; `x_last` high in cycle 8 only; then idle.
- Back-to-back: 8'hA5 then 8'h3C with `din_valid` held high -> 16 consecutive `x_valid` cycles, bits 10100101 00111100, `x_last` in cycles 8 and 16.
- Busy ignore: `din_valid` pulsed with 8'hFF in cycle 3 of a frame -> word not accepted; the frame completes unchanged; `din_ready` = 0 in cycles 1–7.
- Reset mid-frame: `rst` = 0 at edge 4 of an 8'hA5 frame -> `x_valid` = 0 from cycle 5; the next accepted 8'h3C produces a clean 00111100.
- `SERIAL_PARITY_EN`: 8'hA5 -> 9-bit frame ending in parity 0 with `x_last` on bit 9; 8'h07 -> parity bit 1.
